// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDrain
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {instr, pc}; flush wins over push.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [31:0]       push_instr_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    output logic [1:0]        count_o,
    output logic              head_valid_o,
    output logic [31:0]       head_instr_o,
    output logic [ADDR_W-1:0] head_pc_o
);

    logic [31:0]       instr_q [2];
    logic [ADDR_W-1:0] pc_q    [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;
    logic [ADDR_W-1:0] last_pc_q;
    logic              do_pop;

    assign do_pop = pop_i && (count_q != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            last_pc_q <= RESET_PC;
        end else begin
            // pc_o keeps showing the last head once the queue empties
            last_pc_q <= head_pc_o;
            if (flush_i) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                count_q  <= 2'd0;
            end else begin
                if (push_i) begin
                    instr_q[wr_ptr_q] <= push_instr_i;
                    pc_q[wr_ptr_q]    <= push_pc_i;
                    wr_ptr_q          <= ~wr_ptr_q;
                end
                if (do_pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                count_q <= count_q + {1'b0, push_i} - {1'b0, do_pop};
            end
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && (count_q == 2'd2)));

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_instr_o = head_valid_o ? instr_q[rd_ptr_q] : NOP_INSTR;
    assign head_pc_o    = head_valid_o ? pc_q[rd_ptr_q] : last_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, req/ack memory interface, 2-deep queue to decode, redirects.
// Define FETCH_PERF_EN to add saturating transfer and bubble counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count_o,
    output logic [31:0]       bubble_count_o
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              transfer;
    logic              ack;
    logic              push;
    logic              room;
    logic              unused_pc_lsbs;

    assign target         = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign unused_pc_lsbs = ^redirect_pc_i[1:0];
    assign pc_inc         = pc_q + ADDR_W'(PC_STEP);
    assign transfer       = instr_valid_o && instr_ready_i;
    assign ack            = imem_ack_i && imem_req_o;
    // Drained or redirected-away responses never enter the queue
    assign push           = ack && (state_q == StBusy) && !redirect_i;
    assign count_next     = count + {1'b0, push} - {1'b0, transfer};
    assign room           = (count_next <= 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (redirect_i) begin
                    state_d = StBusy;
                    pc_d    = target;
                    addr_d  = target;
                end else if (room) begin
                    state_d = StBusy;
                    addr_d  = pc_q;
                end
            end
            StBusy: begin
                if (redirect_i) begin
                    pc_d = target;
                    if (ack) begin
                        addr_d = target;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (ack) begin
                    pc_d    = pc_inc;
                    addr_d  = pc_inc;
                    state_d = room ? StBusy : StIdle;
                end
            end
            StDrain: begin
                // The wrong-path request must complete before the target is issued
                if (redirect_i) begin
                    pc_d = target;
                end
                if (ack) begin
                    state_d = StBusy;
                    addr_d  = redirect_i ? target : pc_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        imem_req_o  = (state_q != StIdle);
        imem_addr_o = addr_q;
    end

    fetch_buf #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (transfer),
        .flush_i      (redirect_i),
        .push_instr_i (imem_rdata_i),
        .push_pc_i    (addr_q),
        .count_o      (count),
        .head_valid_o (instr_valid_o),
        .head_instr_o (instr_o),
        .head_pc_o    (pc_o)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (transfer && (fetch_cnt_q != 32'hFFFFFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (!instr_valid_o && (bubble_cnt_q != 32'hFFFFFFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count_o  = fetch_cnt_q;
    assign bubble_count_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a combinational-ack memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] KEY = 32'h13579BDF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        ack_en = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_o;
    logic [31:0] bubble_count_o;
`endif

    always #5 clk = ~clk;

    // Memory answers in the same cycle whenever ack_en allows it
    assign imem_ack_i   = imem_req_o & ack_en;
    assign imem_rdata_i = imem_addr_o ^ KEY;

    fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h00000000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count_o  (fetch_count_o),
        .bubble_count_o (bubble_count_o)
`endif
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        ack;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic r, logic rdy, logic ack, logic redir, logic [31:0] rpc,
                                logic req, logic [31:0] addr, logic vld, logic [31:0] pc);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.ack = ack; v.redir = redir; v.rpc = rpc;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
        return v;
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check(string tag, logic req, logic [31:0] addr, logic vld, logic [31:0] pc);
        logic [31:0] exp_instr;
        exp_instr = vld ? (pc ^ KEY) : NOP_INSTR;
        cmp({tag, " req"}, 32'(imem_req_o), 32'(req));
        if (req) cmp({tag, " addr"}, imem_addr_o, addr);
        cmp({tag, " valid"}, 32'(instr_valid_o), 32'(vld));
        cmp({tag, " pc"}, pc_o, pc);
        cmp({tag, " instr"}, instr_o, exp_instr);
    endtask

    // Inputs are driven at a negedge; outputs are sampled at the next negedge
    task automatic step(logic r, logic rdy, logic ack, logic redir, logic [31:0] rpc);
        rst = r; instr_ready_i = rdy; ack_en = ack; redirect_i = redir; redirect_pc_i = rpc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(int i);
        step(vecs[i].rst, vecs[i].rdy, vecs[i].ack, vecs[i].redir, vecs[i].rpc);
        check($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].vld, vecs[i].pc);
    endtask

    initial begin
        //                 rst rdy ack rd  rpc            req addr           vld pc
        // Start-up and streaming
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000000, 0, 32'h00000000));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000004, 1, 32'h00000000));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000008, 1, 32'h00000004));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h0000000C, 1, 32'h00000008));
        // Backpressure for 5 cycles
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h00000010, 1, 32'h00000008));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h00000010, 1, 32'h00000008));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h00000010, 1, 32'h00000008));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h00000010, 1, 32'h00000008));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h00000010, 1, 32'h00000008));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000010, 1, 32'h0000000C));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000014, 1, 32'h00000010));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000018, 1, 32'h00000014));
        // Ack held off 3 cycles
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h00000018, 0, 32'h00000014));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h00000018, 0, 32'h00000014));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h00000018, 0, 32'h00000014));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h0000001C, 1, 32'h00000018));
        // Redirect while waiting for ack -> drain, then fetch at 0x40
        vecs.push_back(mk(0, 1, 0, 1, 32'h00000042, 1, 32'h0000001C, 0, 32'h00000018));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000040, 0, 32'h00000018));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000044, 1, 32'h00000040));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000048, 1, 32'h00000044));
        // Redirect with ack and transfer in the same cycle; pc wraps past 0xFFFFFFFC
        vecs.push_back(mk(0, 1, 1, 1, 32'hFFFFFFFE, 1, 32'hFFFFFFFC, 0, 32'h00000044));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000000, 1, 32'hFFFFFFFC));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000004, 1, 32'h00000000));
        // After the reset sequence: redirect overwrite in drain, flush, redirect from idle
        vecs.push_back(mk(0, 0, 0, 1, 32'h00000100, 1, 32'h00000000, 0, 32'h00000000));
        vecs.push_back(mk(0, 0, 0, 1, 32'h00000203, 1, 32'h00000000, 0, 32'h00000000));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        1, 32'h00000200, 0, 32'h00000000));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        1, 32'h00000204, 1, 32'h00000200));
        vecs.push_back(mk(0, 0, 0, 1, 32'h00000300, 1, 32'h00000204, 0, 32'h00000200));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        1, 32'h00000300, 0, 32'h00000200));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        1, 32'h00000304, 1, 32'h00000300));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h00000308, 1, 32'h00000300));
        vecs.push_back(mk(0, 0, 0, 1, 32'h00000500, 1, 32'h00000500, 0, 32'h00000300));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00000504, 1, 32'h00000500));

        // Reset state, with the memory willing to ack
        step(1, 1, 1, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        check("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        cmp("reset addr", imem_addr_o, 32'h0);

        for (int i = 0; i < 23; i++) run_vec(i);

        // Reset while a request is outstanding and being acked: the ack is dropped
        step(1, 1, 1, 0, 32'h0);
        check("rst_mid", 1'b0, 32'h0, 1'b0, 32'h0);
        cmp("rst_mid addr", imem_addr_o, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("rst_rel", 1'b1, 32'h0, 1'b0, 32'h0);

        for (int i = 23; i < vecs.size(); i++) run_vec(i);

`ifdef FETCH_PERF_EN
        step(1, 0, 0, 0, 32'h0);
        cmp("perf rst fetch", fetch_count_o, 32'd0);
        cmp("perf rst bubble", bubble_count_o, 32'd0);
        // Cycles 1,2 and 9 are bubbles; every other cycle transfers one word
        for (int i = 1; i <= 13; i++) step(0, 1, (i != 8), 0, 32'h0);
        cmp("perf fetch", fetch_count_o, 32'd10);
        cmp("perf bubble", bubble_count_o, 32'd3);
        force dut.fetch_cnt_q = 32'hFFFFFFFF;
        step(0, 0, 1, 0, 32'h0);
        release dut.fetch_cnt_q;
        step(0, 1, 1, 0, 32'h0);
        cmp("perf sat", fetch_count_o, 32'hFFFFFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
